// File: rtl/dds_wave_scheduler_if.sv
// Control/config and DDS-facing signals of the waveform playlist sequencer.
// The sequencer uses the slave modport; the controlling logic uses master.
interface dds_wave_scheduler_if #(
    parameter int FREQ_W  = 32,
    parameter int DWELL_W = 16
);
    logic               cfg_we;
    logic [1:0]         cfg_addr;
    logic [1:0]         cfg_wave;
    logic [FREQ_W-1:0]  cfg_freq;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [1:0]         cfg_len;
    logic               start;
    logic               stop;
    logic               skip;
    logic [3:0]         wave_sel;
    logic [FREQ_W-1:0]  freq_word;
    logic               phase_clr;
    logic               busy;
    logic [1:0]         cur_idx;

    modport master (
        output cfg_we, cfg_addr, cfg_wave, cfg_freq, cfg_dwell, cfg_len,
        output start, stop, skip,
        input  wave_sel, freq_word, phase_clr, busy, cur_idx
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wave, cfg_freq, cfg_dwell, cfg_len,
        input  start, stop, skip,
        output wave_sel, freq_word, phase_clr, busy, cur_idx
    );
endinterface

// File: rtl/dds_wave_scheduler.sv
// Four-entry playlist sequencer driving the DDS wave select, frequency word and
// phase clear; entries advance on dwell expiry, on skip, and restart on start.
module dds_wave_scheduler #(
    parameter int FREQ_W   = 32,
    parameter int DWELL_W  = 16,
    parameter int TICK_DIV = 50000
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    dds_wave_scheduler_if.slave  bus
);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    state_t             state_q;
    logic [1:0]         idx_q;
    logic [1:0]         tbl_wave_q  [4];
    logic [FREQ_W-1:0]  tbl_freq_q  [4];
    logic [DWELL_W-1:0] tbl_dwell_q [4];
    logic [PRE_W-1:0]   presc_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [3:0]         wave_sel_q;
    logic [FREQ_W-1:0]  freq_word_q;
    logic               phase_clr_q;
    logic               busy_q;
    logic [1:0]         cur_idx_q;

    logic               tick_d;
    logic               expire_d;
    logic [1:0]         next_idx_d;

    function automatic logic [3:0] wave_onehot(input logic [1:0] code);
        return 4'b0001 << code;
    endfunction

    // A shrunken cfg_len wraps back to 0 instead of running past the last entry.
    function automatic logic [1:0] advance_idx(input logic [1:0] idx, input logic [1:0] last);
        return (idx >= last) ? 2'd0 : idx + 2'd1;
    endfunction

    always_comb begin
        tick_d     = (presc_q == PRE_LAST);
        expire_d   = tick_d && (dwell_q == DWELL_W'(1));
        next_idx_d = advance_idx(idx_q, bus.cfg_len);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            presc_q     <= '0;
            dwell_q     <= '0;
            wave_sel_q  <= 4'b0000;
            freq_word_q <= '0;
            phase_clr_q <= 1'b0;
            busy_q      <= 1'b0;
            cur_idx_q   <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                tbl_wave_q[i]  <= 2'd0;
                tbl_freq_q[i]  <= '0;
                tbl_dwell_q[i] <= '0;
            end
        end else begin
            phase_clr_q <= 1'b0;

            // Reads below see the pre-write entry when a write and LOAD coincide.
            if (bus.cfg_we) begin
                tbl_wave_q[bus.cfg_addr]  <= bus.cfg_wave;
                tbl_freq_q[bus.cfg_addr]  <= bus.cfg_freq;
                tbl_dwell_q[bus.cfg_addr] <= bus.cfg_dwell;
            end

            if (bus.stop) begin
                state_q     <= ST_IDLE;
                idx_q       <= 2'd0;
                presc_q     <= '0;
                dwell_q     <= '0;
                wave_sel_q  <= 4'b0000;
                freq_word_q <= '0;
                busy_q      <= 1'b0;
                cur_idx_q   <= 2'd0;
            end else if (bus.start) begin
                state_q <= ST_LOAD;
                idx_q   <= 2'd0;
                busy_q  <= 1'b1;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        busy_q <= 1'b0;
                    end
                    ST_LOAD: begin
                        wave_sel_q  <= wave_onehot(tbl_wave_q[idx_q]);
                        freq_word_q <= tbl_freq_q[idx_q];
                        cur_idx_q   <= idx_q;
                        phase_clr_q <= 1'b1;
                        presc_q     <= '0;
                        dwell_q     <= tbl_dwell_q[idx_q];
                        busy_q      <= 1'b1;
                        state_q     <= ST_PLAY;
                    end
                    ST_PLAY: begin
                        if (bus.skip || expire_d) begin
                            idx_q   <= next_idx_d;
                            state_q <= ST_LOAD;
                        end else if (tick_d) begin
                            presc_q <= '0;
                            // Dwell 0 never reaches 1, so it holds until skip/stop.
                            if (dwell_q > DWELL_W'(1)) begin
                                dwell_q <= dwell_q - DWELL_W'(1);
                            end
                        end else begin
                            presc_q <= presc_q + PRE_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.wave_sel  = wave_sel_q;
    assign bus.freq_word = freq_word_q;
    assign bus.phase_clr = phase_clr_q;
    assign bus.busy      = busy_q;
    assign bus.cur_idx   = cur_idx_q;
endmodule

// File: tb/tb_dds_wave_scheduler.sv
// Directed bench for dds_wave_scheduler with TICK_DIV=10: reset, playlist wrap,
// table writes during play, len shrink, restart, skip, stop precedence, table clear.
module tb_dds_wave_scheduler;
    localparam int FREQ_W   = 32;
    localparam int DWELL_W  = 16;
    localparam int TICK_DIV = 10;

    logic sys_clk = 1'b0;
    logic sys_rst;
    int   errors = 0;
    int   checks = 0;
    int   cnt;

    dds_wave_scheduler_if #(.FREQ_W(FREQ_W), .DWELL_W(DWELL_W)) bus ();

    dds_wave_scheduler #(
        .FREQ_W  (FREQ_W),
        .DWELL_W (DWELL_W),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus    (bus.slave)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_entry(input logic [1:0] addr, input logic [1:0] wave,
                               input logic [31:0] freq, input logic [15:0] dwell);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_wave  = wave;
        bus.cfg_freq  = freq;
        bus.cfg_dwell = dwell;
        @(negedge sys_clk);
        bus.cfg_we    = 1'b0;
    endtask

    // Count negedges until phase_clr is seen, bounded by maxc.
    task automatic wait_clr(input int maxc, output int n);
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!bus.phase_clr && n < maxc);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge sys_clk);
        bus.start = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [3:0] ws, input logic [31:0] fw,
                             input logic [1:0] idx);
        check({tag, "_wave"}, 64'(bus.wave_sel), 64'(ws));
        check({tag, "_freq"}, 64'(bus.freq_word), 64'(fw));
        check({tag, "_idx"},  64'(bus.cur_idx), 64'(idx));
    endtask

    initial begin
        sys_rst       = 1'b1;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = 2'd0;
        bus.cfg_wave  = 2'd0;
        bus.cfg_freq  = '0;
        bus.cfg_dwell = '0;
        bus.cfg_len   = 2'd0;
        bus.start     = 1'b1;
        bus.stop      = 1'b0;
        bus.skip      = 1'b0;

        // Reset held with start asserted
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            check("rst_wave", 64'(bus.wave_sel), 64'h0);
            check("rst_freq", 64'(bus.freq_word), 64'h0);
            check("rst_busy", 64'(bus.busy), 64'h0);
            check("rst_clr",  64'(bus.phase_clr), 64'h0);
        end
        sys_rst   = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("post_rst_busy", 64'(bus.busy), 64'h0);
        check("post_rst_wave", 64'(bus.wave_sel), 64'h0);

        // Playlist: sine/3, square/2, triangle/1, cfg_len=2
        write_entry(2'd0, 2'd0, 32'h0001_0000, 16'd3);
        write_entry(2'd1, 2'd1, 32'h0002_0000, 16'd2);
        write_entry(2'd2, 2'd2, 32'h0004_0000, 16'd1);
        bus.cfg_len = 2'd2;
        pulse_start();
        check("load_busy", 64'(bus.busy), 64'h1);
        check("load_wave", 64'(bus.wave_sel), 64'h0);
        @(negedge sys_clk);
        check("e0_clr", 64'(bus.phase_clr), 64'h1);
        check_out("e0", 4'b0001, 32'h0001_0000, 2'd0);
        @(negedge sys_clk);
        check("e0_clr_1cyc", 64'(bus.phase_clr), 64'h0);
        check("e0_hold", 64'(bus.wave_sel), 64'h1);
        // Each entry lasts dwell*10 PLAY cycles plus one LOAD cycle: 31/21/11
        wait_clr(200, cnt);
        check("e0_len", 64'(cnt + 1), 64'd31);
        check_out("e1", 4'b0010, 32'h0002_0000, 2'd1);
        wait_clr(200, cnt);
        check("e1_len", 64'(cnt), 64'd21);
        check_out("e2", 4'b0100, 32'h0004_0000, 2'd2);
        wait_clr(200, cnt);
        check("e2_len", 64'(cnt), 64'd11);
        check_out("wrap", 4'b0001, 32'h0001_0000, 2'd0);

        // Rewrite entry 1 while it plays
        wait_clr(200, cnt);
        check_out("e1b", 4'b0010, 32'h0002_0000, 2'd1);
        write_entry(2'd1, 2'd1, 32'h0008_0000, 16'd2);
        check("wr_nochange", 64'(bus.freq_word), 64'h0002_0000);
        wait_clr(200, cnt);
        check_out("e2b", 4'b0100, 32'h0004_0000, 2'd2);
        wait_clr(200, cnt);
        check_out("e0b", 4'b0001, 32'h0001_0000, 2'd0);
        wait_clr(200, cnt);
        check_out("e1_new", 4'b0010, 32'h0008_0000, 2'd1);

        // Shrink cfg_len while idx 2 plays
        wait_clr(200, cnt);
        check("shr_idx2", 64'(bus.cur_idx), 64'd2);
        bus.cfg_len = 2'd1;
        wait_clr(200, cnt);
        check("shr_wrap0", 64'(bus.cur_idx), 64'd0);
        wait_clr(200, cnt);
        check("shr_idx1", 64'(bus.cur_idx), 64'd1);
        wait_clr(200, cnt);
        check("shr_wrap0b", 64'(bus.cur_idx), 64'd0);

        // Restart mid-entry from idx 1
        wait_clr(200, cnt);
        check("rs_idx1", 64'(bus.cur_idx), 64'd1);
        repeat (5) @(negedge sys_clk);
        pulse_start();
        check("rs_load_clr", 64'(bus.phase_clr), 64'h0);
        check("rs_load_busy", 64'(bus.busy), 64'h1);
        @(negedge sys_clk);
        check("rs_clr", 64'(bus.phase_clr), 64'h1);
        check_out("rs", 4'b0001, 32'h0001_0000, 2'd0);

        // Skip with dwell 0 on entry 0
        write_entry(2'd0, 2'd0, 32'h0001_0000, 16'd0);
        pulse_start();
        @(negedge sys_clk);
        repeat (100) @(negedge sys_clk);
        check_out("hold0", 4'b0001, 32'h0001_0000, 2'd0);
        bus.skip = 1'b1;
        @(negedge sys_clk);
        bus.skip = 1'b0;
        @(negedge sys_clk);
        check("skip_clr", 64'(bus.phase_clr), 64'h1);
        check_out("skip", 4'b0010, 32'h0008_0000, 2'd1);

        // Stop and skip on the same edge
        repeat (3) @(negedge sys_clk);
        bus.stop = 1'b1;
        bus.skip = 1'b1;
        @(negedge sys_clk);
        bus.stop = 1'b0;
        bus.skip = 1'b0;
        check_out("stop", 4'b0000, 32'h0, 2'd0);
        check("stop_busy", 64'(bus.busy), 64'h0);
        check("stop_clr", 64'(bus.phase_clr), 64'h0);
        @(negedge sys_clk);
        check("stop_clr2", 64'(bus.phase_clr), 64'h0);
        check("stop_wave2", 64'(bus.wave_sel), 64'h0);

        // Reset mid-play clears the table: entry 0 reloads as sine with freq 0
        pulse_start();
        repeat (4) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check_out("rst_mid", 4'b0000, 32'h0, 2'd0);
        pulse_start();
        @(negedge sys_clk);
        check_out("cleared", 4'b0001, 32'h0, 2'd0);
        check("cleared_clr", 64'(bus.phase_clr), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
